isw_share_codec: RTL

- Boundary block for the second-order (3-share) masked datapath.
- The encoder side splits an unmasked W-bit word into 3 Boolean shares using 2 fresh random words, and feeds them to ISW-style gadgets behind a valid/ready handshake.
- The decoder side recombines 3 result shares from the gadgets through a 2-stage register pipeline, producing the unmasked word.
- An unmasked value is never stored in a register on the encode path.

---
 rtl/isw_share_codec.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/isw_share_codec.sv
// -----------------------------------------------------------------------------
// isw_share_codec
//
// Boundary block for the second-order (3-share) masked datapath.
//
// Encoder: splits an unmasked word into three Boolean shares using two fresh
// random words and presents them to the gadgets through a 1-entry output
// buffer (EMPTY/FULL).
//
// Decoder: recombines three result shares through a 2-stage register pipeline
// into the unmasked word. There is no backpressure on this path.
//
// Valid/ready: a transfer happens on a port in any cycle where its valid and
// ready are both high. The sender must hold data stable while valid is high
// and ready is low. in_ready_o may depend combinationally on out_ready_i and
// rnd_valid_i. rnd_ack_o pulses in exactly the cycles where rnd0_i/rnd1_i are
// consumed.
//
// Ports:
//   clk_i, rst_ni             clock (rising edge), async active-low reset
//   plain_i, in_valid_i       unmasked word in / valid
//   in_ready_o                encoder accepts plain_i this cycle
//   rnd0_i, rnd1_i            fresh randomness words
//   rnd_valid_i, rnd_ack_o    randomness usable / consumed this cycle
//   S0_o, S1_o, S2_o          shares (S0 = plain^rnd0^rnd1, S1 = rnd0, S2 = rnd1)
//   out_valid_o, out_ready_i  share handshake; out_valid_o is the FSM state bit
//   D0_i, D1_i, D2_i          result shares from the gadgets
//   dec_valid_i               result shares valid
//   plain_o, plain_valid_o    recombined word / 1-cycle valid pulse
//   enc_cnt_o                 saturating count of encoded words
// -----------------------------------------------------------------------------
module isw_share_codec #(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [W-1:0]     plain_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [W-1:0]     rnd0_i,
    input  logic [W-1:0]     rnd1_i,
    input  logic             rnd_valid_i,
    output logic             rnd_ack_o,
    output logic [W-1:0]     S0_o,
    output logic [W-1:0]     S1_o,
    output logic [W-1:0]     S2_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    input  logic [W-1:0]     D0_i,
    input  logic [W-1:0]     D1_i,
    input  logic [W-1:0]     D2_i,
    input  logic             dec_valid_i,
    output logic [W-1:0]     plain_o,
    output logic             plain_valid_o,
    output logic [CNT_W-1:0] enc_cnt_o
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } enc_state_e;

    enc_state_e state_q, state_d;

    logic           accept;
    logic [W-1:0]   s0_q, s1_q, s2_q;
    logic [W-1:0]   masked_lo;
    logic [W-1:0]   s0_d;
    logic [CNT_W-1:0] cnt_q;

    logic [W-1:0]   p01_q, p2_q;
    logic           v1_q;
    logic [W-1:0]   plain_q;
    logic           plain_valid_q;

    // ------------------------------------------------------------------
    // Encoder
    // ------------------------------------------------------------------

    // The buffer can take a new word when it is empty or is being drained
    // in this same cycle; randomness must be available either way.
    assign in_ready_o = rnd_valid_i & ((state_q == EMPTY) | out_ready_i);
    assign accept     = in_valid_i & in_ready_o;
    assign rnd_ack_o  = accept;

    // plain is masked by rnd0 first, then by rnd1; only the fully masked
    // result reaches a register, so the unmasked word is never stored.
    assign masked_lo = plain_i ^ rnd0_i;
    assign s0_d      = masked_lo ^ rnd1_i;

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = FULL;
        end else if ((state_q == FULL) && out_ready_i) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s0_q <= '0;
            s1_q <= '0;
            s2_q <= '0;
        end else if (accept) begin
            s0_q <= s0_d;
            s1_q <= rnd0_i;
            s2_q <= rnd1_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (accept && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign S0_o        = s0_q;
    assign S1_o        = s1_q;
    assign S2_o        = s2_q;
    assign out_valid_o = (state_q == FULL);
    assign enc_cnt_o   = cnt_q;

    // ------------------------------------------------------------------
    // Decoder
    // ------------------------------------------------------------------

    // Stage 1: fold shares 0 and 1 together, carry share 2 alongside.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            p01_q <= '0;
            p2_q  <= '0;
            v1_q  <= 1'b0;
        end else begin
            v1_q <= dec_valid_i;
            if (dec_valid_i) begin
                p01_q <= D0_i ^ D1_i;
                p2_q  <= D2_i;
            end
        end
    end

    // Stage 2: final recombination; plain_o holds between valid words.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            plain_q       <= '0;
            plain_valid_q <= 1'b0;
        end else begin
            plain_valid_q <= v1_q;
            if (v1_q) begin
                plain_q <= p01_q ^ p2_q;
            end
        end
    end

    assign plain_o       = plain_q;
    assign plain_valid_o = plain_valid_q;

endmodule
